hdc_classify_ctrl: RTL and testbench
====================================

// Module: hdc_classify_ctrl
// PURPOSE
// - Sequencer for the HDC spam/ham classifier datapath: walks a latched message char by char into the
//   encoder, triggers bundle thresholding, runs two similarity compares (HAM then SPAM class HV), emits label.
// - Sits between the message source (test bench / host loader) and encoder, bundler and comparator units.
// PARAMETERS
// - CHAR_W   8    bits per character
// - MAX_LEN  160  max characters in msg
// - DIST_W   14   width of Hamming distance returned by comparator
// - TIMEOUT  1024 watchdog limit in cycles (used only with HDC_CTRL_TIMEOUT_EN)
// PORTS
// - clk            in   1               single clock, rising edge
// - reset          in   1               asynchronous, active-high
// - start          in   1               begin classification (honoured only in IDLE)
// - msg            in   CHAR_W*MAX_LEN  message; char i = msg[CHAR_W*(MAX_LEN-i)-1 -: CHAR_W]; stable while busy
// - length         in   8               valid char count, latched on start
// - busy           out  1               high from cycle after accepted start until done
// - done           out  1               one-cycle pulse, result valid
// - result         out  2               00 none, 01 HAM, 10 SPAM, 11 error; held until next accepted start
// - enc_valid      out  1               char presented to encoder
// - enc_char       out  CHAR_W          current char
// - enc_first      out  1               high with char 0 (encoder resets n-gram window)
// - enc_ready      in   1               encoder accepts char when enc_valid&enc_ready
// - bundle_clr     out  1               pulse: clear bundling accumulator
// - bundle_thresh  out  1               pulse: threshold accumulator into query HV
// - thresh_done    in   1               query HV ready
// - cmp_start      out  1               pulse: start compare
// - cmp_sel        out  1               0 = HAM class HV, 1 = SPAM class HV; held through compare
// - cmp_done       in   1               compare finished, cmp_dist valid this cycle
// - cmp_dist       in   DIST_W          Hamming distance query vs selected class HV
// BEHAVIOUR
// - Reset: state IDLE; busy, done, enc_*, bundle_*, cmp_start, cmp_sel = 0; result = 00; idx, dist regs = 0.
// - Reset mid-operation aborts immediately; no pulse completes; next start behaves as after power-up.
// - FSM: IDLE -> ENCODE -> THRESH -> CMP_HAM -> CMP_SPAM -> DONE -> IDLE.
// - IDLE: start=1 latches length, pulses bundle_clr (same edge transition), idx=0, result=00.
//   length==0 or >MAX_LEN: go DONE directly, result=11; no encoder/bundle/compare activity besides bundle_clr.
// - ENCODE: enc_valid=1 first cycle after start; enc_char=char[idx]; handshake increments idx, next char
//   presented next cycle with no bubble; valid never drops until last handshake (idx==length-1).
// - THRESH: bundle_thresh pulsed on entry cycle; wait thresh_done (sampled from the cycle after the pulse).
// - CMP_HAM/CMP_SPAM: cmp_start pulsed on entry with cmp_sel 0/1; wait cmp_done (not sampled in pulse
//   cycle); capture cmp_dist into d_ham / d_spam.
// - DONE: result = (d_spam < d_ham) ? 10 : 01 (tie -> HAM, 01); done=1 one cycle; busy drops same cycle.
// - Latency: 1 + length (zero-stall) + thresh wait + 2 compare waits + 1 cycles from start to done.
// - start while busy ignored; stray thresh_done/cmp_done outside their wait state ignored.
// - Distances compared unsigned, full DIST_W width.
// CONFIGURATION
// - HDC_CTRL_TIMEOUT_EN defined: per-wait-state counter (ENCODE per char, THRESH, CMP_*); reaching TIMEOUT
//   cycles without handshake -> DONE with result=11, outputs to encoder/comparator deasserted.
// - Not defined: waits indefinitely; counter logic absent.
// STRUCTURE
// - hdc_pkg (shared header): CHAR_W, MAX_LEN defaults, RES_NONE/RES_HAM/RES_SPAM/RES_ERR codes, state encodings.
// - Sub-module hdc_char_sel: combinational msg/idx -> enc_char mux, reused by the loader.
// - FSM, idx counter, distance regs, optional watchdog live in this module.
// TESTING
// - length=5 "hello", enc_ready=1 always -> 5 enc_valid cycles, enc_first on 'h' only, bundle_thresh once.
// - enc_ready toggling 1-0-1 -> enc_char holds during stalls; each char accepted exactly once, in order.
// - d_ham=3000, d_spam=4200 -> result=01; swapped -> 10; both 3500 -> 01; done one cycle, busy low after.
// - length=0 and length=200 -> result=11 within 2 cycles of start, cmp_start never asserted.
// - reset asserted during CMP_SPAM -> all outputs 0 same cycle; new start with length=3 completes normally.
// - TIMEOUT_EN, TIMEOUT=16, thresh_done never asserted -> result=11, done 16 cycles after bundle_thresh.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC classifier: default sizes, result codes,
// controller state encoding and the final class decision.
package hdc_pkg;

    localparam int CHAR_W_DEF  = 8;
    localparam int MAX_LEN_DEF = 160;
    localparam int DIST_W_DEF  = 14;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_HAM  = 2'b01,
        RES_SPAM = 2'b10,
        RES_ERR  = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_THRESH,
        ST_CMP_HAM,
        ST_CMP_SPAM,
        ST_DONE
    } state_e;

    // Smaller Hamming distance wins; a tie goes to HAM.
    function automatic result_e classify(input logic [31:0] d_ham, input logic [31:0] d_spam);
        return (d_spam < d_ham) ? RES_SPAM : RES_HAM;
    endfunction

endpackage

// File: rtl/hdc_char_sel.sv
// Combinational character picker: returns char idx of a packed message,
// where char 0 occupies the most significant CHAR_W bits.
module hdc_char_sel
    import hdc_pkg::*;
#(
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int IDX_W   = 8
) (
    input  logic [CHAR_W*MAX_LEN-1:0] msg,
    input  logic [IDX_W-1:0]          idx,
    output logic [CHAR_W-1:0]         ch
);

    always_comb begin
        ch = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                ch = msg[CHAR_W*(MAX_LEN-i)-1 -: CHAR_W];
            end
        end
    end

endmodule

// File: rtl/hdc_classify_ctrl.sv
// Sequencer for the HDC spam/ham classifier: encode chars, threshold, compare
// against HAM then SPAM class HVs, report label. Optional watchdog: HDC_CTRL_TIMEOUT_EN.
module hdc_classify_ctrl
    import hdc_pkg::*;
#(
    parameter int CHAR_W  = CHAR_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int DIST_W  = DIST_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CHAR_W*MAX_LEN-1:0] msg,
    input  logic [7:0]                length,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                result,
    output logic                      enc_valid,
    output logic [CHAR_W-1:0]         enc_char,
    output logic                      enc_first,
    input  logic                      enc_ready,
    output logic                      bundle_clr,
    output logic                      bundle_thresh,
    input  logic                      thresh_done,
    output logic                      cmp_start,
    output logic                      cmp_sel,
    input  logic                      cmp_done,
    input  logic [DIST_W-1:0]         cmp_dist
);

    state_e              state_q, state_d;
    logic [7:0]          idx_q, idx_d;
    logic [7:0]          len_q, len_d;
    logic [DIST_W-1:0]   d_ham_q, d_ham_d;
    logic [DIST_W-1:0]   d_spam_q, d_spam_d;
    result_e             result_q, result_d;
    logic                bundle_clr_q, bundle_clr_d;
    logic                bundle_thresh_q, bundle_thresh_d;
    logic                cmp_start_q, cmp_start_d;
    logic [CHAR_W-1:0]   sel_char;
    logic                wd_expire;
    result_e             result_now;

    hdc_char_sel #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (MAX_LEN),
        .IDX_W   (8)
    ) u_char_sel (
        .msg (msg),
        .idx (idx_q),
        .ch  (sel_char)
    );

    assign busy          = (state_q == ST_ENCODE) || (state_q == ST_THRESH) ||
                           (state_q == ST_CMP_HAM) || (state_q == ST_CMP_SPAM);
    assign done          = (state_q == ST_DONE);
    assign enc_valid     = (state_q == ST_ENCODE);
    assign enc_char      = enc_valid ? sel_char : '0;
    assign enc_first     = enc_valid && (idx_q == '0);
    assign cmp_sel       = (state_q == ST_CMP_SPAM);
    assign bundle_clr    = bundle_clr_q;
    assign bundle_thresh = bundle_thresh_q;
    assign cmp_start     = cmp_start_q;

    // An error code is already latched on entry to DONE; otherwise decide from the captured distances.
    assign result_now = (done && result_q == RES_NONE) ? classify(32'(d_ham_q), 32'(d_spam_q)) : result_q;
    assign result     = result_now;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a latch behind.
        state_d         = state_q;
        idx_d           = idx_q;
        len_d           = len_q;
        d_ham_d         = d_ham_q;
        d_spam_d        = d_spam_q;
        result_d        = result_q;
        bundle_clr_d    = 1'b0;
        bundle_thresh_d = 1'b0;
        cmp_start_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d        = length;
                    idx_d        = '0;
                    result_d     = RES_NONE;
                    bundle_clr_d = 1'b1;
                    if (length == '0 || int'(length) > MAX_LEN) begin
                        state_d  = ST_DONE;
                        result_d = RES_ERR;
                    end else begin
                        state_d  = ST_ENCODE;
                    end
                end
            end
            ST_ENCODE: begin
                if (enc_ready) begin
                    if (idx_q == len_q - 8'd1) begin
                        state_d         = ST_THRESH;
                        bundle_thresh_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else if (wd_expire) begin
                    state_d  = ST_DONE;
                    result_d = RES_ERR;
                end
            end
            ST_THRESH: begin
                // thresh_done is ignored while the threshold pulse itself is out.
                if (!bundle_thresh_q && thresh_done) begin
                    state_d     = ST_CMP_HAM;
                    cmp_start_d = 1'b1;
                end else if (wd_expire) begin
                    state_d  = ST_DONE;
                    result_d = RES_ERR;
                end
            end
            ST_CMP_HAM: begin
                if (!cmp_start_q && cmp_done) begin
                    d_ham_d     = cmp_dist;
                    state_d     = ST_CMP_SPAM;
                    cmp_start_d = 1'b1;
                end else if (wd_expire) begin
                    state_d  = ST_DONE;
                    result_d = RES_ERR;
                end
            end
            ST_CMP_SPAM: begin
                if (!cmp_start_q && cmp_done) begin
                    d_spam_d = cmp_dist;
                    state_d  = ST_DONE;
                end else if (wd_expire) begin
                    state_d  = ST_DONE;
                    result_d = RES_ERR;
                end
            end
            ST_DONE: begin
                result_d = result_now;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            len_q           <= '0;
            d_ham_q         <= '0;
            d_spam_q        <= '0;
            result_q        <= RES_NONE;
            bundle_clr_q    <= 1'b0;
            bundle_thresh_q <= 1'b0;
            cmp_start_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            state_q         <= state_d;
            idx_q           <= idx_d;
            len_q           <= len_d;
            d_ham_q         <= d_ham_d;
            d_spam_q        <= d_spam_d;
            result_q        <= result_d;
            bundle_clr_q    <= bundle_clr_d;
            bundle_thresh_q <= bundle_thresh_d;
            cmp_start_q     <= cmp_start_d;
        end
    end

`ifdef HDC_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Restarts on every state change and every accepted char, so each wait is timed separately.
    always_comb begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (!busy || state_d != state_q || (enc_valid && enc_ready)) begin
            wd_cnt_d = '0;
        end
    end

    assign wd_expire = busy && (wd_cnt_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// Directed self-checking bench for hdc_classify_ctrl; inputs driven and outputs
// checked on the falling edge. Watchdog steps build only with HDC_CTRL_TIMEOUT_EN.
module tb_hdc_classify_ctrl;

    localparam int CHAR_W  = 8;
    localparam int MAX_LEN = 160;
    localparam int DIST_W  = 14;
    localparam int TIMEOUT = 16;

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic [CHAR_W*MAX_LEN-1:0] msg;
    logic [7:0]                length;
    logic                      busy;
    logic                      done;
    logic [1:0]                result;
    logic                      enc_valid;
    logic [CHAR_W-1:0]         enc_char;
    logic                      enc_first;
    logic                      enc_ready;
    logic                      bundle_clr;
    logic                      bundle_thresh;
    logic                      thresh_done;
    logic                      cmp_start;
    logic                      cmp_sel;
    logic                      cmp_done;
    logic [DIST_W-1:0]         cmp_dist;

    logic [7:0] chars [0:MAX_LEN-1];
    int n_tests = 0;
    int n_fail  = 0;

    hdc_classify_ctrl #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (MAX_LEN),
        .DIST_W  (DIST_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .msg           (msg),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .enc_valid     (enc_valid),
        .enc_char      (enc_char),
        .enc_first     (enc_first),
        .enc_ready     (enc_ready),
        .bundle_clr    (bundle_clr),
        .bundle_thresh (bundle_thresh),
        .thresh_done   (thresh_done),
        .cmp_start     (cmp_start),
        .cmp_sel       (cmp_sel),
        .cmp_done      (cmp_done),
        .cmp_dist      (cmp_dist)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_str(input string s);
        for (int k = 0; k < MAX_LEN; k++) begin
            chars[k] = (k < s.len()) ? s[k] : 8'h2e;
        end
        for (int k = 0; k < MAX_LEN; k++) begin
            msg[CHAR_W*(MAX_LEN-k)-1 -: CHAR_W] = chars[k];
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < MAX_LEN; k++) begin
            chars[k] = 8'(8'h21 + (k % 90));
            msg[CHAR_W*(MAX_LEN-k)-1 -: CHAR_W] = chars[k];
        end
    endtask

    task automatic do_start(input logic [7:0] len);
        length = len;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Entered on the first ENCODE cycle; leaves on the THRESH entry cycle.
    // With stall set, enc_ready runs 1-0-1-0 and start/length are disturbed to prove they are ignored.
    task automatic encode(input int len, input bit stall);
        int  k   = 0;
        int  cyc = 0;
        bit  rdy;
        while (k < len && cyc < 4 * len + 8) begin
            check("enc_valid", 32'(enc_valid), 32'd1);
            check("enc_char", 32'(enc_char), 32'(chars[k]));
            check("enc_first", 32'(enc_first), 32'(k == 0));
            check("bundle_clr", 32'(bundle_clr), 32'(cyc == 0));
            check("busy_enc", 32'(busy), 32'd1);
            check("result_cleared", 32'(result), 32'd0);
            check("no_thresh_in_enc", 32'(bundle_thresh), 32'd0);
            rdy       = stall ? (cyc % 2 == 0) : 1'b1;
            enc_ready = rdy;
            if (stall) begin
                start  = 1'b1;
                length = 8'd2;
            end
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        start     = 1'b0;
        enc_ready = 1'b0;
        check("enc_accept_count", 32'(k), 32'(len));
        check("enc_valid_off", 32'(enc_valid), 32'd0);
        check("bundle_thresh_pulse", 32'(bundle_thresh), 32'd1);
    endtask

    // Entered on the THRESH entry cycle; stray thresh_done/cmp_done in the pulse cycles must be ignored.
    task automatic finish_cmp(input logic [DIST_W-1:0] ham, input logic [DIST_W-1:0] spam,
                              input logic [1:0] exp);
        thresh_done = 1'b1;
        @(negedge clk);
        check("thresh_single", 32'(bundle_thresh), 32'd0);
        check("thresh_wait", 32'(cmp_start), 32'd0);
        check("busy_thresh", 32'(busy), 32'd1);
        @(negedge clk);
        thresh_done = 1'b0;
        check("cmp_start_ham", 32'(cmp_start), 32'd1);
        check("cmp_sel_ham", 32'(cmp_sel), 32'd0);
        cmp_done = 1'b1;
        cmp_dist = '0;
        @(negedge clk);
        check("cmp_start_ham_off", 32'(cmp_start), 32'd0);
        check("cmp_sel_ham_hold", 32'(cmp_sel), 32'd0);
        cmp_dist = ham;
        @(negedge clk);
        cmp_done = 1'b0;
        check("cmp_start_spam", 32'(cmp_start), 32'd1);
        check("cmp_sel_spam", 32'(cmp_sel), 32'd1);
        @(negedge clk);
        check("cmp_start_spam_off", 32'(cmp_start), 32'd0);
        check("cmp_sel_spam_hold", 32'(cmp_sel), 32'd1);
        check("not_done_yet", 32'(done), 32'd0);
        cmp_done = 1'b1;
        cmp_dist = spam;
        @(negedge clk);
        cmp_done = 1'b0;
        cmp_dist = '0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_drop", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(exp));
        check("cmp_sel_done", 32'(cmp_sel), 32'd0);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("result_hold", 32'(result), 32'(exp));
    endtask

    task automatic bad_len(input logic [7:0] len);
        do_start(len);
        check("bad_done", 32'(done), 32'd1);
        check("bad_result", 32'(result), 32'd3);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_bundle_clr", 32'(bundle_clr), 32'd1);
        check("bad_enc_valid", 32'(enc_valid), 32'd0);
        check("bad_cmp_start", 32'(cmp_start), 32'd0);
        check("bad_thresh", 32'(bundle_thresh), 32'd0);
        @(negedge clk);
        check("bad_done_single", 32'(done), 32'd0);
        check("bad_result_hold", 32'(result), 32'd3);
        check("bad_cmp_start_after", 32'(cmp_start), 32'd0);
        check("bad_enc_after", 32'(enc_valid), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        msg         = '0;
        length      = '0;
        enc_ready   = 1'b0;
        thresh_done = 1'b0;
        cmp_done    = 1'b0;
        cmp_dist    = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_enc_valid", 32'(enc_valid), 32'd0);
        check("rst_enc_char", 32'(enc_char), 32'd0);
        check("rst_enc_first", 32'(enc_first), 32'd0);
        check("rst_bundle_clr", 32'(bundle_clr), 32'd0);
        check("rst_bundle_thresh", 32'(bundle_thresh), 32'd0);
        check("rst_cmp_start", 32'(cmp_start), 32'd0);
        check("rst_cmp_sel", 32'(cmp_sel), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // "hello", no stalls, HAM closer.
        load_str("hello");
        do_start(8'd5);
        encode(5, 1'b0);
        finish_cmp(14'd3000, 14'd4200, 2'b01);

        // Stalled encoder, SPAM closer.
        load_str("world");
        do_start(8'd5);
        encode(5, 1'b1);
        finish_cmp(14'd4200, 14'd3000, 2'b10);

        // Tie goes to HAM.
        load_str("abc");
        do_start(8'd3);
        encode(3, 1'b0);
        finish_cmp(14'd3500, 14'd3500, 2'b01);

        // Single char, distances at the top of the unsigned range.
        load_str("z");
        do_start(8'd1);
        encode(1, 1'b0);
        finish_cmp(14'd16383, 14'd16382, 2'b10);

        // Full-length message.
        load_ramp();
        do_start(8'(MAX_LEN));
        encode(MAX_LEN, 1'b1);
        finish_cmp(14'd0, 14'd1, 2'b01);

        // Stray handshakes while idle change nothing.
        thresh_done = 1'b1;
        cmp_done    = 1'b1;
        @(negedge clk);
        thresh_done = 1'b0;
        cmp_done    = 1'b0;
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_done", 32'(done), 32'd0);
        check("stray_cmp_start", 32'(cmp_start), 32'd0);

        bad_len(8'd0);
        bad_len(8'd200);

        // Reset in the middle of CMP_SPAM, then a clean run.
        load_str("cat");
        do_start(8'd3);
        encode(3, 1'b0);
        thresh_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        thresh_done = 1'b0;
        @(negedge clk);
        cmp_done = 1'b1;
        cmp_dist = 14'd100;
        @(negedge clk);
        cmp_done = 1'b0;
        check("pre_rst_cmp_sel", 32'(cmp_sel), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_enc_valid", 32'(enc_valid), 32'd0);
        check("abort_enc_char", 32'(enc_char), 32'd0);
        check("abort_enc_first", 32'(enc_first), 32'd0);
        check("abort_bundle_clr", 32'(bundle_clr), 32'd0);
        check("abort_bundle_thresh", 32'(bundle_thresh), 32'd0);
        check("abort_cmp_start", 32'(cmp_start), 32'd0);
        check("abort_cmp_sel", 32'(cmp_sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_str("dog");
        do_start(8'd3);
        encode(3, 1'b0);
        finish_cmp(14'd10, 14'd20, 2'b01);

`ifdef HDC_CTRL_TIMEOUT_EN
        // thresh_done never arrives: watchdog ends the run with an error code.
        begin
            int n = 0;
            load_str("hello");
            do_start(8'd5);
            encode(5, 1'b0);
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (done) begin
                    n = i;
                    break;
                end
                check("wd_no_cmp_start", 32'(cmp_start), 32'd0);
            end
            check("wd_latency", 32'(n), 32'd16);
            check("wd_result", 32'(result), 32'd3);
            check("wd_enc_valid", 32'(enc_valid), 32'd0);
            check("wd_cmp_start", 32'(cmp_start), 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
